fir_sample_source: RTL
======================

Name: fir_sample_source

Overview:
Streaming sample transmitter that feeds the fir_sync filter input. It stores up to DEPTH signed samples loaded through a simple write port. On command it plays them out over a valid/ready stream, either once or looping continuously. This replaces ad-hoc stimulus arrays: the same pattern memory drives the FIR in both simulation and on-chip self-test.

Parameters:
DATA_W, 10, sample width (two's complement); matches fir_sync din.
DEPTH, 100, number of sample slots in pattern memory.
ADDR_W, 7, address/length width; must satisfy 2^ADDR_W > DEPTH.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst  in  1  asynchronous, active-low reset.
wr_en  in  1  write strobe into pattern memory.
wr_addr  in  ADDR_W  write address, 0..DEPTH-1.
wr_data  in  DATA_W  signed sample to store.
length  in  ADDR_W  number of samples to play; sampled on start.
loop  in  1  1 = wrap to sample 0 after last; sampled on start.
start  in  1  begin playback (pulse).
stop  in  1  abort playback (pulse).
dout  out  DATA_W  signed sample to the FIR.
dout_valid  out  1  dout holds a valid sample.
dout_ready  in  1  downstream accepts the sample this cycle.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when a non-loop playback completes.
err  out  1  one-cycle pulse when start is rejected.
sample_idx  out  ADDR_W  index of the sample currently on dout.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - dout, dout_valid, busy, done, err, sample_idx are all 0.
  - Pattern memory is not reset.
- Memory writes:
  - Accepted only when state is IDLE, wr_en = 1 and wr_addr < DEPTH.
  - Writes are silently ignored otherwise, including while busy.
- FSM states: IDLE, PRIME, PLAY, DONE.
- IDLE:
  - start with 1 <= length <= DEPTH: latch length and loop, set the read pointer to 0, go to PRIME.
  - start with length 0 or length > DEPTH: pulse err for one cycle and stay in IDLE.
- PRIME (one cycle):
  - dout <= mem[0], dout_valid <= 1, sample_idx <= 0.
  - Go to PLAY.
  - The first valid sample therefore appears 2 cycles after the start edge.
- PLAY:
  - A handshake is dout_valid & dout_ready.
  - With no handshake, dout, dout_valid and sample_idx hold stable.
  - On a handshake at an index below length-1: load the next sample from memory with no bubble (one sample per cycle while ready stays high).
  - On a handshake at index length-1 with loop = 1: reload mem[0] and set sample_idx = 0, no bubble.
  - On a handshake at index length-1 with loop = 0: dout_valid <= 0, go to DONE.
- DONE (one cycle): done = 1, then return to IDLE.
- stop:
  - In PRIME or PLAY: dout_valid <= 0 and return to IDLE next cycle, with no done pulse.
  - stop has priority over a simultaneous handshake; the sample in flight is considered transferred only if ready was high that cycle.
  - Ignored in IDLE and DONE.
- start while busy: ignored.
- dout is a registered output with no combinational path from dout_ready.
- After dout_valid falls, dout keeps its last value.
- Reset mid-playback aborts immediately; the next start replays from sample 0 with the memory contents retained.

Decomposition:
- Shared package fir_pkg holds:
  - FIR_DATA_W = 10, the input width shared with fir_sync.
  - FIR_OUT_W = 11.
  - The FSM state encoding: 2 bits, with IDLE = 0, PRIME = 1, PLAY = 2, DONE = 3.
- One sub-module, fir_pattern_ram:
  - DEPTH x DATA_W storage.
  - Synchronous write, asynchronous read.
  - Keeps storage inference separate from the FSM.

Test Plan:
1. Single-shot playback:
   - Stimulus: write -36, -480, 486 at addresses 0..2; length = 3, loop = 0, ready held 1; start.
   - Response: dout = 10'h3DC, 10'h220, 10'h1E6 on consecutive cycles starting 2 cycles after start; done pulses once on the next cycle; busy then falls.
2. Backpressure:
   - Stimulus: same pattern; ready toggles 1,0,0,1,1.
   - Response: 10'h220 is held stable for 3 cycles with dout_valid = 1; no sample is skipped or duplicated; sample_idx tracks 0,1,1,1,2.
3. Loop wrap:
   - Stimulus: length = 2 with samples 294, -49; loop = 1; ready = 1 for 6 cycles.
   - Response: dout sequence 294, -49, 294, -49, 294, -49 with no bubble; done never asserts.
4. Illegal start:
   - Stimulus: start with length = 0, then again with length = 101.
   - Response: err pulses once each time; busy stays 0; dout_valid stays 0.
5. Stop and write protection:
   - Stimulus: stop during PLAY at sample_idx 1, asserted with ready = 1 in the same cycle; a write to address 0 is also attempted while busy.
   - Response: dout_valid is 0 on the next cycle; state returns to IDLE; no done pulse; a replay shows mem[0] is unchanged.
6. Asynchronous reset mid-stream:
   - Stimulus: assert rst low between clock edges during PLAY.
   - Response: dout_valid and busy drop immediately; after release, a new start replays the stored pattern from index 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared FIR constants and the sample-source FSM encoding.
// Pure declarations: no latency, no flow control.
package fir_pkg;
    localparam int FIR_DATA_W = 10;
    localparam int FIR_OUT_W  = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_PLAY  = 2'd2,
        ST_DONE  = 2'd3
    } src_state_e;
endpackage

// File: rtl/fir_sample_source_if.sv
// Sample stream from the pattern source into the FIR input.
// Valid/ready: a sample transfers on a clock edge where both are high.
interface fir_sample_source_if #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 7
);
    logic signed [DATA_W-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic        [ADDR_W-1:0] sample_idx;

    modport master (output dout, output dout_valid, output sample_idx, input  dout_ready);
    modport slave  (input  dout, input  dout_valid, input  sample_idx, output dout_ready);
endinterface

// File: rtl/fir_pattern_ram.sv
// Pattern storage: synchronous write, asynchronous read, no reset.
// Zero-latency read; no flow control.
module fir_pattern_ram #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 7
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic        [ADDR_W-1:0] wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic        [ADDR_W-1:0] rd_addr,
    output logic signed [DATA_W-1:0] rd_data
);
    logic signed [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/fir_sample_source.sv
// Plays stored samples once or looping onto a valid/ready stream; first sample 2 cycles after start.
// Output is fully registered; dout/sample_idx hold while ready is low, stop aborts without done.
module fir_sample_source
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = 100,
    parameter int ADDR_W = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic        [ADDR_W-1:0] wr_addr,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic        [ADDR_W-1:0] length,
    input  logic                     loop,
    input  logic                     start,
    input  logic                     stop,
    fir_sample_source_if.master      src,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    src_state_e               state_q, state_d;
    logic signed [DATA_W-1:0] dout_q, dout_d;
    logic                     vld_q, vld_d;
    logic        [ADDR_W-1:0] idx_q, idx_d;
    logic        [ADDR_W-1:0] len_q, len_d;
    logic                     loop_q, loop_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                     hs;
    logic                     more;
    logic                     ram_we;
    logic        [ADDR_W-1:0] rd_addr;
    logic signed [DATA_W-1:0] rd_data;

    assign hs     = vld_q & src.dout_ready;
    assign more   = idx_q < (len_q - 1'b1);
    assign ram_we = (state_q == ST_IDLE) && wr_en && (wr_addr < DEPTH_A);
    // Only a mid-pattern advance reads beyond slot 0; prime and wrap both read slot 0.
    assign rd_addr = (state_q == ST_PLAY && hs && more) ? idx_q + 1'b1 : '0;

    fir_pattern_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        vld_d   = vld_q;
        idx_d   = idx_q;
        len_d   = len_q;
        loop_d  = loop_q;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != '0 && length <= DEPTH_A) begin
                        len_d   = length;
                        loop_d  = loop;
                        idx_d   = '0;
                        state_d = ST_PRIME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_PRIME: begin
                if (stop) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    dout_d  = rd_data;
                    vld_d   = 1'b1;
                    idx_d   = '0;
                    state_d = ST_PLAY;
                end
            end
            ST_PLAY: begin
                // stop wins over a same-cycle handshake
                if (stop) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                end else if (hs) begin
                    if (more) begin
                        dout_d = rd_data;
                        idx_d  = idx_q + 1'b1;
                    end else if (loop_q) begin
                        dout_d = rd_data;
                        idx_d  = '0;
                    end else begin
                        vld_d   = 1'b0;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign src.dout       = dout_q;
    assign src.dout_valid = vld_q;
    assign src.sample_idx = idx_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
endmodule
